// File: rtl/vme_bus_requester.sv
// vme_bus_requester
//   VME bus requester for one request level. Drives BR on LEVEL, runs the
//   bus-grant daisy chain for all four levels, and drives BBSY while this
//   board owns the bus. Supports release-when-done (RWD) and
//   release-on-request (ROR), with a minimum BBSY hold.
//
//   Optional feature macro: VME_ARB_TIMEOUT_EN. When it is defined, a request
//   that gets no grant within GRANT_TIMEOUT cycles is abandoned.
//
// Ports (vme_* and the handshake signals are active-low):
//   clock, reset        system clock, synchronous active-high reset
//   request_vme         board wants the bus
//   transfer_busy       data transfer FSM mid-cycle (on-chip, not synchronised)
//   bus_acquired        board owns the bus
//   arb_timeout         one-cycle active-high pulse when a request is abandoned
//   vme_bus_request     BR3..BR0 drive (only bit LEVEL is ever active)
//   vme_br_in           sensed BR lines
//   vme_bus_grant_in    BG0IN..BG3IN
//   vme_bus_grant_out   BG0OUT..BG3OUT
//   vme_bbsy_out        BBSY drive
//   vme_bbsy_in         sensed BBSY
module vme_bus_requester #(
  parameter int LEVEL              = 3,
  parameter int RELEASE_ON_REQUEST = 0,
  parameter int MIN_BBSY_CYCLES    = 4,
  parameter int GRANT_TIMEOUT      = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       request_vme,
  input  logic       transfer_busy,
  output logic       bus_acquired,
  output logic       arb_timeout,
  output logic [3:0] vme_bus_request,
  input  logic [3:0] vme_br_in,
  input  logic [3:0] vme_bus_grant_in,
  output logic [3:0] vme_bus_grant_out,
  output logic       vme_bbsy_out,
  input  logic       vme_bbsy_in
);

  typedef enum logic [1:0] {IDLE, REQUEST, OWNED, RELEASE} state_t;

  localparam logic [3:0] HOLD_MAX  = 4'(MIN_BBSY_CYCLES);
  localparam logic [3:0] HOLD_LAST = 4'(MIN_BBSY_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] hold, hold_next;
  logic [3:0] br_p0, br_p1, gnt_p0, gnt_p1;
  logic       bbsy_p0, bbsy_p1;
  logic [3:0] br_next, gout_next;
  logic       bbsy_next, acq_next, tmo_next;
  logic       granted, release_req;

`ifdef VME_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(GRANT_TIMEOUT - 1);
  logic [15:0] tmo_cnt, tmo_cnt_next;
  logic        rearm_block, rearm_block_next;
`else
  logic unused_cfg;
  assign unused_cfg = ^16'(GRANT_TIMEOUT);
`endif

  assign granted     = !gnt_p1[LEVEL];
  // Our own BR is already released while OWNED, so any active BR is another board.
  assign release_req = request_vme || ((RELEASE_ON_REQUEST != 0) && (br_p1 != 4'hF));

  always_comb begin
    state_next        = state;
    hold_next         = hold;
    br_next           = vme_bus_request;
    bbsy_next         = vme_bbsy_out;
    acq_next          = bus_acquired;
    tmo_next          = 1'b0;
    gout_next         = gnt_p1;
    gout_next[LEVEL]  = 1'b1;
`ifdef VME_ARB_TIMEOUT_EN
    tmo_cnt_next      = tmo_cnt;
    rearm_block_next  = rearm_block;
`endif
    case (state)
      IDLE: begin
        // Only an idle requester passes the grant down the chain.
        gout_next[LEVEL] = gnt_p1[LEVEL];
        br_next          = 4'hF;
        bbsy_next        = 1'b1;
        acq_next         = 1'b1;
`ifdef VME_ARB_TIMEOUT_EN
        tmo_cnt_next = '0;
        if (request_vme) rearm_block_next = 1'b0;
        if (!request_vme && !rearm_block) begin
`else
        if (!request_vme) begin
`endif
          state_next     = REQUEST;
          br_next[LEVEL] = 1'b0;
        end
      end
      REQUEST: begin
        if (granted && bbsy_p1) begin
          state_next = OWNED;
          bbsy_next  = 1'b0;
          br_next    = 4'hF;
          hold_next  = '0;
        end else if (request_vme) begin
          state_next = IDLE;
          br_next    = 4'hF;
        end
`ifdef VME_ARB_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          state_next       = IDLE;
          br_next          = 4'hF;
          tmo_next         = 1'b1;
          rearm_block_next = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt + 16'd1;
        end
`endif
      end
      OWNED: begin
        if (hold != HOLD_MAX) hold_next = hold + 4'd1;
        // hold reaching HOLD_LAST means this edge completes the minimum BBSY
        // time; bus_acquired must already have been shown for one cycle.
        if (hold >= HOLD_LAST && !bus_acquired && transfer_busy && release_req) begin
          state_next = RELEASE;
          acq_next   = 1'b1;
        end else begin
          acq_next = 1'b0;
        end
      end
      RELEASE: begin
        acq_next = 1'b1;
        // Keep BBSY until our grant input is gone so the arbiter never sees
        // BBSY drop while BGIN is still asserted.
        if (!granted) begin
          bbsy_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      hold              <= '0;
      br_p0             <= 4'hF;
      br_p1             <= 4'hF;
      gnt_p0            <= 4'hF;
      gnt_p1            <= 4'hF;
      bbsy_p0           <= 1'b1;
      bbsy_p1           <= 1'b1;
      vme_bus_request   <= 4'hF;
      vme_bus_grant_out <= 4'hF;
      vme_bbsy_out      <= 1'b1;
      bus_acquired      <= 1'b1;
      arb_timeout       <= 1'b0;
`ifdef VME_ARB_TIMEOUT_EN
      tmo_cnt           <= '0;
      rearm_block       <= 1'b0;
`endif
    end else begin
      // stage p0 -> p1: two-flop synchronisers on the bus inputs
      br_p0             <= vme_br_in;
      br_p1             <= br_p0;
      gnt_p0            <= vme_bus_grant_in;
      gnt_p1            <= gnt_p0;
      bbsy_p0           <= vme_bbsy_in;
      bbsy_p1           <= bbsy_p0;
      // registered FSM state and outputs
      state             <= state_next;
      hold              <= hold_next;
      vme_bus_request   <= br_next;
      vme_bus_grant_out <= gout_next;
      vme_bbsy_out      <= bbsy_next;
      bus_acquired      <= acq_next;
      arb_timeout       <= tmo_next;
`ifdef VME_ARB_TIMEOUT_EN
      tmo_cnt           <= tmo_cnt_next;
      rearm_block       <= rearm_block_next;
`endif
    end
  end

endmodule
